// File: rtl/dm_access_unit.sv
// Data-memory load/store unit: turns one datapath access into a word-aligned bus
// transaction with byte enables and returns extended load data or an error.
module dm_access_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned AW      = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_dmtype,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_be,
   output logic [31:0]   bus_wdata,
   input  logic          bus_ack,
   input  logic [31:0]   bus_rdata
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   localparam logic [2:0] DT_W  = 3'b000;
   localparam logic [2:0] DT_H  = 3'b001;
   localparam logic [2:0] DT_B  = 3'b010;
   localparam logic [2:0] DT_HU = 3'b011;
   localparam logic [2:0] DT_BU = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    dmtype_q, dmtype_d;
   logic [1:0]    off_q, off_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]    bus_be_q, bus_be_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;

   logic          illegal;
   logic          misaligned;
   logic [CW-1:0] cnt_inc;
   logic          timeout_hit;

   function automatic logic [3:0] byte_enables(input logic [2:0] dt, input logic [1:0] off);
      case (dt)
         DT_W:         byte_enables = 4'b1111;
         DT_H, DT_HU:  byte_enables = 4'b0011 << off;
         DT_B, DT_BU:  byte_enables = 4'b0001 << off;
         default:      byte_enables = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] dt, input logic [31:0] word,
                                               input logic [1:0] off);
      logic [31:0] s;
      s = word >> {off, 3'b000};
      case (dt)
         DT_H:    load_extend = {{16{s[15]}}, s[15:0]};
         DT_HU:   load_extend = {16'h0000, s[15:0]};
         DT_B:    load_extend = {{24{s[7]}}, s[7:0]};
         DT_BU:   load_extend = {24'h000000, s[7:0]};
         default: load_extend = s;
      endcase
   endfunction

   assign illegal    = (req_dmtype > DT_BU);
   assign misaligned = (((req_dmtype == DT_H) || (req_dmtype == DT_HU)) && req_addr[0]) ||
                       ((req_dmtype == DT_W) && (req_addr[1:0] != 2'b00));
   assign cnt_inc     = cnt_q + CW'(1);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      dmtype_d    = dmtype_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               dmtype_d    = req_dmtype;
               off_d       = req_addr[1:0];
               cnt_d       = '0;
               req_ready_d = 1'b0;
               // Error requests never touch the bus; they respond one cycle later.
               if (illegal || misaligned) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else begin
                  state_d     = S_BUS;
                  bus_req_d   = 1'b1;
                  bus_we_d    = req_we;
                  bus_addr_d  = {req_addr[AW-1:2], 2'b00};
                  bus_be_d    = byte_enables(req_dmtype, req_addr[1:0]);
                  bus_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
               end
            end
         end

         S_BUS: begin
            // An ack arriving together with the final timeout count still wins.
            if (bus_ack || timeout_hit) begin
               state_d     = S_RESP;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_be_d    = 4'b0000;
               bus_wdata_d = 32'h0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = !bus_ack;
               rsp_rdata_d = (bus_ack && !we_q) ? load_extend(dmtype_q, bus_rdata, off_q) : 32'h0;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_inc;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            bus_req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         dmtype_q    <= DT_W;
         off_q       <= 2'b00;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         dmtype_q    <= dmtype_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed and randomized accesses against an
// arithmetic model of sizes, lanes and extension, with TIMEOUT = 4.
module tb_dm_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_dmtype;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int testsRun = 0;
   int testsFailed = 0;

   dm_access_unit #(.TIMEOUT(TO), .AW(32)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Model: access width in bytes, 0 for an illegal code.
   function automatic int unsigned sizeOf(input logic [2:0] dt);
      case (dt)
         3'd0:       return 4;
         3'd1, 3'd3: return 2;
         3'd2, 3'd4: return 1;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] dt, input logic [31:0] word,
                                             input logic [31:0] addr);
      longint unsigned w64;
      longint          m;
      longint          v;
      int unsigned     size;
      size = sizeOf(dt);
      w64  = longint'(word);
      m    = longint'(1) << (8 * size);
      v    = longint'((w64 >> (8 * (addr % 4))) % longint'(m));
      if ((dt == 3'd1 || dt == 3'd2) && v >= m / 2) v = v - m;
      return 32'(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Holds the response for 'hold' cycles while offering a competing request and stray acks.
   task automatic finishResponse(input logic [31:0] eRdata, input logic eErr, input int hold);
      for (int h = 0; h < hold; h++) begin
         checkOutput("hold_rsp_valid", rsp_valid, 1);
         checkOutput("hold_rsp_rdata", rsp_rdata, eRdata);
         checkOutput("hold_rsp_err", rsp_err, eErr);
         checkOutput("hold_req_ready", req_ready, 0);
         checkOutput("hold_bus_req", bus_req, 0);
         req_valid  = 1'b1;
         req_we     = 1'b0;
         req_dmtype = 3'd0;
         req_addr   = 32'h0000_7000;
         bus_ack    = 1'b1;
         bus_rdata  = $urandom;
         step();
         bus_ack = 1'b0;
      end
      req_valid = 1'b0;
      checkOutput("rsp_valid_before_ready", rsp_valid, 1);
      checkOutput("rsp_rdata", rsp_rdata, eRdata);
      checkOutput("rsp_err", rsp_err, eErr);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_dropped", rsp_valid, 0);
      checkOutput("req_ready_back", req_ready, 1);
      checkOutput("no_bus_after_rsp", bus_req, 0);
   endtask

   // waits < 0 means the slave never acknowledges.
   task automatic applyStimulus(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                                input logic [31:0] wdata, input int waits, input logic [31:0] word,
                                input int hold);
      int unsigned size;
      logic        eErr;
      logic [31:0] eRdata;
      logic [7:0]  beWide;
      size   = sizeOf(dt);
      eErr   = (size == 0) || ((addr % size) != 0);
      beWide = ((8'd1 << size) - 8'd1) << (addr % 4);
      checkOutput("req_ready_idle", req_ready, 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_dmtype = dt;
      req_addr   = addr;
      req_wdata  = wdata;
      step();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (eErr) begin
         eRdata = 32'h0;
         checkOutput("err_no_bus_req", bus_req, 0);
         checkOutput("err_rsp_valid_c1", rsp_valid, 1);
      end else if (waits < 0) begin
         eErr   = 1'b1;
         eRdata = 32'h0;
         for (int c = 0; c < TO; c++) begin
            checkOutput("to_bus_req_high", bus_req, 1);
            checkOutput("to_rsp_valid_low", rsp_valid, 0);
            step();
         end
         checkOutput("to_bus_req_dropped", bus_req, 0);
      end else begin
         eRdata = we ? 32'h0 : modelLoad(dt, word, addr);
         for (int c = 0; c <= waits; c++) begin
            checkOutput("bus_req", bus_req, 1);
            checkOutput("bus_we", bus_we, we);
            checkOutput("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            checkOutput("bus_be", bus_be, beWide[3:0]);
            checkOutput("bus_wdata", bus_wdata, wdata << (8 * (addr % 4)));
            checkOutput("rsp_valid_during_bus", rsp_valid, 0);
            checkOutput("req_ready_during_bus", req_ready, 0);
            if (c == waits) begin
               bus_ack   = 1'b1;
               bus_rdata = word;
            end
            step();
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
         end
         checkOutput("bus_req_dropped", bus_req, 0);
      end
      finishResponse(eRdata, eErr, hold);
   endtask

   initial begin
      logic        rWe;
      logic [2:0]  rDt;
      logic [31:0] rAddr;
      rstn       = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_dmtype = 3'd0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;
      bus_ack    = 1'b0;
      bus_rdata  = 32'h0;
      step();
      step();
      checkOutput("reset_req_ready", req_ready, 1);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_bus_req", bus_req, 0);
      checkOutput("reset_bus_be", bus_be, 0);
      rstn = 1'b1;
      step();

      applyStimulus(1'b0, 3'd2, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234, 1);
      applyStimulus(1'b0, 3'd3, 32'h0000_2002, 32'h0, 0, 32'h9ABC_0000, 0);
      applyStimulus(1'b1, 3'd2, 32'h0000_3001, 32'h0000_00A5, 1, 32'h1234_5678, 0);
      applyStimulus(1'b0, 3'd0, 32'h0000_4002, 32'h0, 0, 32'h0, 1);
      applyStimulus(1'b1, 3'd1, 32'h0000_4001, 32'h1111_2222, 0, 32'h0, 0);
      applyStimulus(1'b0, 3'd6, 32'h0000_4000, 32'h0, 0, 32'h0, 0);
      applyStimulus(1'b0, 3'd0, 32'h0000_6000, 32'h0, TO - 1, 32'hDEAD_BEEF, 0);
      applyStimulus(1'b0, 3'd0, 32'h0000_5000, 32'h0, -1, 32'h0, 2);
      applyStimulus(1'b0, 3'd1, 32'h0000_5002, 32'h0, 0, 32'h8001_0000, 5);

      // Reset asserted while the bus transaction is outstanding.
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_dmtype = 3'd0;
      req_addr   = 32'h0000_8004;
      req_wdata  = 32'hCAFE_F00D;
      step();
      req_valid = 1'b0;
      step();
      checkOutput("pre_reset_bus_req", bus_req, 1);
      rstn = 1'b0;
      #1;
      checkOutput("mid_reset_bus_req", bus_req, 0);
      checkOutput("mid_reset_bus_we", bus_we, 0);
      checkOutput("mid_reset_bus_addr", bus_addr, 0);
      checkOutput("mid_reset_bus_wdata", bus_wdata, 0);
      checkOutput("mid_reset_req_ready", req_ready, 1);
      checkOutput("mid_reset_rsp_valid", rsp_valid, 0);
      step();
      rstn    = 1'b1;
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      step();
      checkOutput("post_reset_rsp_valid", rsp_valid, 0);
      checkOutput("post_reset_req_ready", req_ready, 1);

      for (int i = 0; i < 40; i++) begin
         rWe   = 1'($urandom_range(0, 1));
         rDt   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         rAddr = $urandom;
         if ($urandom_range(0, 1) == 1) rAddr[1:0] = 2'b00;
         applyStimulus(rWe, rDt, rAddr, $urandom, int'($urandom_range(0, TO - 1)), $urandom,
                       int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
